puzzle_scheduler: RTL
=====================

PUZZLE_SCHEDULER -- requirements
Module: puzzle_scheduler

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000000, Clock cycles per one-second tick.
REQ-002 SHALL have parameter TIMEOUT_S, default 20, seconds allowed per puzzle before the alarm resumes.
REQ-003 SHALL have parameter MAX_WRONG, default 3, wrong verdicts tolerated before escalation to the sequencer puzzle.
REQ-004 Clock  in  1  single system clock; all state changes on its rising edge.
REQ-005 Reset  in  1  asynchronous, active-low reset (0 = reset).
REQ-006 Start  in  1  level; 1 = alarm armed/firing, 0 = abort to IDLE.
REQ-007 Go  in  1  one-cycle pulse; user acknowledges ringing alarm.
REQ-008 eq_done  in  1  one-cycle pulse; active equation checker has a verdict.
REQ-009 eq_correct  in  1  verdict, sampled only when eq_done=1.
REQ-010 seq_done  in  1  one-cycle pulse; sequencer puzzle solved.
REQ-011 start_eq  out  3  one-hot enable for equation checkers 1..3.
REQ-012 start_seq  out  1  enable for sequencer puzzle.
REQ-013 alarm_on  out  1  drive audio/LED alarm.
REQ-014 Timer  out  7  seconds remaining in current puzzle.
REQ-015 wrong_count  out  4  wrong verdicts in current puzzle run.
REQ-016 done  out  1  alarm dismissed.

Function
REQ-017 SHALL implement states IDLE, RING, EQ1, EQ2, EQ3, SEQ, DONE; all outputs registered (one-cycle latency from state entry).
REQ-018 IDLE: Start=1 -> RING; else stay.
REQ-019 RING: alarm_on=1; Go -> EQ1.
REQ-020 EQn: start_eq bit n-1 =1; eq_done with eq_correct=1 -> next EQ (EQ3 -> DONE); wrong_count cleared on advance.
REQ-021 EQn: eq_done with eq_correct=0 -> wrong_count+1, stay; if incremented value equals MAX_WRONG -> SEQ, wrong_count cleared.
REQ-022 SEQ: start_seq=1; seq_done -> DONE.
REQ-023 DONE: done=1; Start=0 -> IDLE.
REQ-024 Start=0 in any state except IDLE SHALL force IDLE next cycle, outputs cleared; abort wins over all other events.
REQ-025 Prescaler SHALL count 0..TICK_DIV-1, clear on every state change, emit one-cycle tick at terminal count.
REQ-026 Entering EQn or SEQ SHALL load Timer=TIMEOUT_S; each tick decrements; Timer saturates at 0; Timer=0 outside EQn/SEQ.
REQ-027 Tick taking Timer 1->0 in EQn/SEQ SHALL return to RING, wrong_count cleared, puzzle restarts at EQ1.
REQ-028 eq_done or seq_done coincident with timeout tick: verdict SHALL win.
REQ-029 Go outside RING, eq_done outside EQn, seq_done outside SEQ SHALL be ignored.
REQ-030 wrong_count SHALL saturate at 15.

Reset
REQ-031 Reset=0 SHALL asynchronously force IDLE, prescaler 0, Timer 0, wrong_count 0, start_eq 0, start_seq 0, alarm_on 0, done 0.
REQ-032 Reset deassertion SHALL be synchronised externally; first evaluation on first rising edge with Reset=1.

Structure
REQ-033 State encoding and TIMEOUT_S/MAX_WRONG/TICK_DIV defaults SHALL live in shared package alarm_pkg.
REQ-034 Prescaler plus Timer SHALL be sub-module puzzle_timer (load, tick, Timer, expired).

Verification (TICK_DIV=4, TIMEOUT_S=3, MAX_WRONG=2)
REQ-035 Start=1, Go, three eq_done/eq_correct=1 -> start_eq 001,010,100 in order, then done=1; Start=0 -> IDLE.
REQ-036 In EQ2, two eq_done/eq_correct=0 -> wrong_count 1 then SEQ, start_seq=1, wrong_count=0; seq_done -> done=1.
REQ-037 In EQ1, no verdict for 12 cycles -> Timer 3,2,1,0 then RING, alarm_on=1.
REQ-038 eq_done/eq_correct=1 same cycle as Timer 1->0 tick in EQ3 -> DONE, not RING.
REQ-039 Reset=0 mid-EQ2 with wrong_count=1 -> all outputs 0 immediately, no clock edge needed.
REQ-040 Start=0 same cycle as eq_done/eq_correct=1 in EQ1 -> IDLE, start_eq=000.

Source files
------------

// File: rtl/alarm_pkg.sv
// rtl/alarm_pkg.sv - shared state encoding and timing defaults for the puzzle scheduler
package alarm_pkg;

    localparam int DEF_TICK_DIV  = 50000000;
    localparam int DEF_TIMEOUT_S = 20;
    localparam int DEF_MAX_WRONG = 3;

    localparam int TIMER_W = 7;
    localparam int WRONG_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RING = 3'd1,
        ST_EQ1  = 3'd2,
        ST_EQ2  = 3'd3,
        ST_EQ3  = 3'd4,
        ST_SEQ  = 3'd5,
        ST_DONE = 3'd6
    } state_t;

    // Puzzle states are the ones that run against the countdown.
    function automatic logic is_puzzle(input state_t s);
        return (s == ST_EQ1) || (s == ST_EQ2) || (s == ST_EQ3) || (s == ST_SEQ);
    endfunction

endpackage

// File: rtl/puzzle_timer.sv
// rtl/puzzle_timer.sv - one-second prescaler and per-puzzle countdown
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   clear       : state is changing this cycle, restart the prescaler
//   load        : entering a puzzle state, reload the countdown
//   run         : next state is a puzzle state (countdown held at 0 otherwise)
//   timer       : seconds remaining
//   expired     : the tick in this cycle takes the countdown from 1 to 0
module puzzle_timer
    import alarm_pkg::*;
#(
    parameter int TICK_DIV  = DEF_TICK_DIV,
    parameter int TIMEOUT_S = DEF_TIMEOUT_S
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               load,
    input  logic               run,
    output logic [TIMER_W-1:0] timer,
    output logic               expired
);

    localparam int              PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_MAX = PW'(TICK_DIV - 1);

    logic [PW-1:0]      presc_q, presc_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               tick;

    assign tick    = (presc_q == PRESC_MAX);
    assign expired = tick && (timer_q == TIMER_W'(1));
    assign timer   = timer_q;

    always_comb begin
        presc_d = (clear || tick) ? '0 : presc_q + 1'b1;
        if (load) begin
            timer_d = TIMER_W'(TIMEOUT_S);
        end else if (!run) begin
            timer_d = '0;
        end else if (tick && (timer_q != '0)) begin
            timer_d = timer_q - 1'b1;
        end else begin
            timer_d = timer_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            timer_q <= '0;
        end else begin
            presc_q <= presc_d;
            timer_q <= timer_d;
        end
    end

endmodule

// File: rtl/puzzle_scheduler.sv
// rtl/puzzle_scheduler.sv - alarm puzzle sequencing FSM with per-puzzle timeout
// Ports:
//   Clock, Reset      : clock, asynchronous active-low reset
//   Start             : level, 1 = alarm armed, 0 = abort to idle
//   Go                : pulse, user acknowledges the ringing alarm
//   eq_done/eq_correct: equation checker verdict pulse and value
//   seq_done          : pulse, sequencer puzzle solved
//   start_eq/start_seq: one-hot puzzle enables
//   alarm_on, Timer, wrong_count, done : registered status outputs
module puzzle_scheduler
    import alarm_pkg::*;
#(
    parameter int TICK_DIV  = DEF_TICK_DIV,
    parameter int TIMEOUT_S = DEF_TIMEOUT_S,
    parameter int MAX_WRONG = DEF_MAX_WRONG
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Start,
    input  logic               Go,
    input  logic               eq_done,
    input  logic               eq_correct,
    input  logic               seq_done,
    output logic [2:0]         start_eq,
    output logic               start_seq,
    output logic               alarm_on,
    output logic [TIMER_W-1:0] Timer,
    output logic [WRONG_W-1:0] wrong_count,
    output logic               done
);

    localparam logic [WRONG_W-1:0] MAX_WRONG_W = WRONG_W'(MAX_WRONG);

    state_t             state_q, state_d;
    logic [WRONG_W-1:0] wrong_q, wrong_d, wrong_inc;
    logic [2:0]         start_eq_q, start_eq_d;
    logic               start_seq_q, start_seq_d;
    logic               alarm_on_q, alarm_on_d;
    logic               done_q, done_d;
    logic               state_change, expired;

    always_comb begin
        state_d   = state_q;
        wrong_d   = wrong_q;
        wrong_inc = (wrong_q == '1) ? wrong_q : wrong_q + 1'b1;
        if (!Start) begin
            // Abort outranks every other event, including a verdict.
            state_d = ST_IDLE;
            wrong_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_RING;
                ST_RING: if (Go) state_d = ST_EQ1;
                ST_EQ1, ST_EQ2, ST_EQ3: begin
                    // A verdict in the same cycle as the timeout tick wins.
                    if (eq_done) begin
                        if (eq_correct) begin
                            state_d = (state_q == ST_EQ1) ? ST_EQ2 :
                                      (state_q == ST_EQ2) ? ST_EQ3 : ST_DONE;
                            wrong_d = '0;
                        end else if (wrong_inc == MAX_WRONG_W) begin
                            state_d = ST_SEQ;
                            wrong_d = '0;
                        end else begin
                            wrong_d = wrong_inc;
                        end
                    end else if (expired) begin
                        state_d = ST_RING;
                        wrong_d = '0;
                    end
                end
                ST_SEQ: begin
                    if (seq_done) begin
                        state_d = ST_DONE;
                    end else if (expired) begin
                        state_d = ST_RING;
                        wrong_d = '0;
                    end
                end
                ST_DONE: state_d = ST_DONE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so they are registered yet
    // line up with the state register.
    always_comb begin
        start_eq_d  = {state_d == ST_EQ3, state_d == ST_EQ2, state_d == ST_EQ1};
        start_seq_d = (state_d == ST_SEQ);
        alarm_on_d  = (state_d == ST_RING);
        done_d      = (state_d == ST_DONE);
    end

    assign state_change = (state_d != state_q);

    puzzle_timer #(
        .TICK_DIV  (TICK_DIV),
        .TIMEOUT_S (TIMEOUT_S)
    ) u_timer (
        .clk     (Clock),
        .rst_n   (Reset),
        .clear   (state_change),
        .load    (state_change && is_puzzle(state_d)),
        .run     (is_puzzle(state_d)),
        .timer   (Timer),
        .expired (expired)
    );

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q     <= ST_IDLE;
            wrong_q     <= '0;
            start_eq_q  <= '0;
            start_seq_q <= 1'b0;
            alarm_on_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wrong_q     <= wrong_d;
            start_eq_q  <= start_eq_d;
            start_seq_q <= start_seq_d;
            alarm_on_q  <= alarm_on_d;
            done_q      <= done_d;
        end
    end

    assign start_eq    = start_eq_q;
    assign start_seq   = start_seq_q;
    assign alarm_on    = alarm_on_q;
    assign wrong_count = wrong_q;
    assign done        = done_q;

endmodule
